// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for a raster-order pixel map.
// Two row-length shift buffers hold the previous two rows. Each accepted pixel
// pushes a new column {row-2, row-1, current} into a 3x3 window register. A
// window is flagged valid only when it lies entirely inside the image.
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [DW-1:0]       pix_data,
    output logic                win_valid,
    output logic [8:0][DW-1:0]  win_data,
    output logic                win_last,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            col_q;
    logic [RW-1:0]            row_q;
    logic                     pix_ready_q;
    logic                     win_valid_q;
    logic                     win_last_q;
    logic                     busy_q;
    logic                     done_q;

    // lb0 holds row-1, lb1 holds row-2; element IMG_W-1 is the oldest entry,
    // i.e. the pixel in the same column one (lb0) or two (lb1) rows back.
    logic [IMG_W-1:0][DW-1:0] lb0_q, lb0_d;
    logic [IMG_W-1:0][DW-1:0] lb1_q, lb1_d;
    logic [8:0][DW-1:0]       win_q, win_d;

    logic accept;
    logic col_last;
    logic row_last;

    assign accept   = pix_valid & pix_ready_q;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // Frame sequencing: position counters and all registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pix_ready_q <= 1'b0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        col_q       <= '0;
                        row_q       <= '0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        // Window is complete only once two full rows and two
                        // columns of the current row are behind it; this also
                        // suppresses windows straddling a row wrap.
                        win_valid_q <= (row_q >= ROW_MIN) && (col_q >= COL_MIN);
                        win_last_q  <= row_last && col_last;
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                state_q     <= S_DONE;
                                pix_ready_q <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Next-state of line buffers and window: shift only on an accepted pixel.
    always_comb begin
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        win_d = win_q;
        if (accept) begin
            lb0_d = {lb0_q[IMG_W-2:0], pix_data};
            lb1_d = {lb1_q[IMG_W-2:0], lb0_q[IMG_W-1]};
            for (int r = 0; r < 3; r++) begin
                win_d[r*3 + 0] = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb1_q[IMG_W-1];
            win_d[5] = lb0_q[IMG_W-1];
            win_d[8] = pix_data;
        end
    end

    // Line buffer and window storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb0_q <= '0;
            lb1_q <= '0;
            win_q <= '0;
        end else begin
            lb0_q <= lb0_d;
            lb1_q <= lb1_d;
            win_q <= win_d;
        end
    end

    assign pix_ready = pix_ready_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_data  = win_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
